spi_register_bank: RTL and testbench

// - SPI Mode-0 slave, write-oriented. Receives 16-bit frames from an external SPI master and updates
//   the 9 x 8-bit control registers that configure the downstream PWM peripheral.
// - Sits between the chip pins (sclk/copi/ncs/cipo) and the PWM peripheral's reg_* inputs.
// - SPI pins are asynchronous to clk. They are synchronized internally and sampled in the clk domain.

---
 rtl/spi_register_bank.sv | 193 +++++++++++++++++++
 tb/tb_spi_register_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_register_bank.sv
// spi_register_bank: SPI Mode-0 write-oriented slave that drives the PWM control registers.
// Frames are 16 bits, MSB first: {W, addr[6:0], data[7:0]}.
// SPI pins are synchronized into the clk domain and edge-detected before use.
// Optional feature: define SPI_READBACK_EN to shift register contents out on cipo for W=0 frames.
module spi_register_bank #(
    parameter int unsigned NUM_REGS    = 9,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] reg_en_out,
    output logic [7:0] reg_en_pwm_out,
    output logic [7:0] reg_out_3_0_pwm_gen_channel,
    output logic [7:0] reg_out_7_4_pwm_gen_channel,
    output logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_0_frequency_divider,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_hist, copi_hist, ncs_hist;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];
    logic        valid_d, err_d;

    // Synchronizer chains plus one history flop per SPI input. Reset to 0 so that a
    // chip select already low at reset release is never seen as a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_hist <= 1'b0;
            copi_hist <= 1'b0;
            ncs_hist  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            copi_hist <= copi_sync[SYNC_STAGES-1];
            ncs_hist  <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
    assign ncs_rise  = ncs_sync[SYNC_STAGES-1] & ~ncs_hist;
    assign ncs_fall  = ~ncs_sync[SYNC_STAGES-1] & ncs_hist;

    // Frame FSM, shift register and register-file next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        regs_d  = regs_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = RECV;
                    cnt_d   = 5'd0;
                    shreg_d = 16'h0000;
                end
            end
            RECV: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    // copi_hist lines up with the sclk_sync/sclk_hist pair used for the rise.
                    shreg_d = {shreg_q[14:0], copi_hist};
                    // Saturate at 17 so any overlong frame stays distinguishable from 16.
                    if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (cnt_q == 5'd16) begin
                    if (shreg_q[15]) begin
                        if (shreg_q[14:8] < NUM_REGS_A) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (shreg_q[14:8] == 7'(i)) regs_d[i] = shreg_q[7:0];
                            end
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
`ifdef SPI_READBACK_EN
                        err_d = (shreg_q[14:8] >= NUM_REGS_A);
`else
                        err_d = 1'b0;
`endif
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, register file and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            shreg_q     <= 16'h0000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_valid <= valid_d;
            frame_err   <= err_d;
            regs_q      <= regs_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] first8;
    logic [7:0] rd_sel;
    logic [7:0] rd_q, rd_d;

    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_hist;
    // The first 8 received bits (W + addr) as they will stand after this sclk rise.
    assign first8    = {shreg_q[6:0], copi_hist};

    // Select the register addressed by the header; unimplemented addresses read as 0.
    always_comb begin
        rd_sel = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (first8[6:0] == 7'(i)) rd_sel = regs_q[i];
        end
    end

    // Readback shifter: load on the 8th rise, advance on each fall once the master
    // has sampled the current bit (count >= 9).
    always_comb begin
        rd_d = rd_q;
        if (state_q != RECV) begin
            rd_d = 8'h00;
        end else if (!ncs_rise && sclk_rise && cnt_q == 5'd7) begin
            rd_d = (!first8[7] && first8[6:0] < NUM_REGS_A) ? rd_sel : 8'h00;
        end else if (sclk_fall && cnt_q >= 5'd9) begin
            rd_d = {rd_q[6:0], 1'b0};
        end
    end

    // Readback shift register; cipo comes straight from its MSB flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= 8'h00;
        else        rd_q <= rd_d;
    end

    assign cipo = rd_q[7];
`else
    assign cipo = 1'b0;
`endif

    assign reg_en_out                        = regs_q[0];
    assign reg_en_pwm_out                    = regs_q[1];
    assign reg_out_3_0_pwm_gen_channel       = regs_q[2];
    assign reg_out_7_4_pwm_gen_channel       = regs_q[3];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_q[4];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_q[5];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_q[6];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_q[7];
    assign reg_pwm_gen_1_0_frequency_divider = regs_q[8];

endmodule

// File: tb/tb_spi_register_bank.sv
// Testbench for spi_register_bank: directed SPI frames, expected pulses queued in a
// scoreboard and checked by an independent monitor on the falling clock edge.
module tb_spi_register_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs = 1'b1;
    logic cipo, frame_valid, frame_err;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

    spi_register_bank dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .sclk                              (sclk),
        .copi                              (copi),
        .ncs                               (ncs),
        .cipo                              (cipo),
        .reg_en_out                        (r0),
        .reg_en_pwm_out                    (r1),
        .reg_out_3_0_pwm_gen_channel       (r2),
        .reg_out_7_4_pwm_gen_channel       (r3),
        .reg_pwm_gen_0_ch_0_duty_cycle     (r4),
        .reg_pwm_gen_0_ch_1_duty_cycle     (r5),
        .reg_pwm_gen_1_ch_0_duty_cycle     (r6),
        .reg_pwm_gen_1_ch_1_duty_cycle     (r7),
        .reg_pwm_gen_1_0_frequency_divider (r8),
        .frame_valid                       (frame_valid),
        .frame_err                         (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic            err;
        logic [31:0]     cyc;
        logic [8:0][7:0] regs;
    } exp_t;

    exp_t            sb[$];
    logic [8:0][7:0] model;
    logic [8:0][7:0] dut_regs;
    int              n_chk = 0;
    int              n_pass = 0;

    assign dut_regs = {r8, r7, r6, r5, r4, r3, r2, r1, r0};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock out the n low bits of v MSB first; capture cipo before the rises of bits 7..0.
    task automatic send_bits(input logic [16:0] v, input int n,
                             output logic [7:0] rd, output logic seen);
        rd   = 8'h00;
        seen = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            wait_clks(4);
            if (i < 8) rd = {rd[6:0], cipo};
            seen = seen | cipo;
            sclk = 1'b1;
            wait_clks(4);
            seen = seen | cipo;
            sclk = 1'b0;
        end
    endtask

    // Full frame; kind 0 = no pulse expected, 1 = frame_valid, 2 = frame_err.
    task automatic frame(input logic [16:0] v, input int n, input int kind, input int gap,
                         output logic [7:0] rd, output logic seen);
        exp_t e;
        ncs = 1'b0;
        wait_clks(4);
        send_bits(v, n, rd, seen);
        wait_clks(4);
        ncs = 1'b1;
        if (kind != 0) begin
            e.err  = (kind == 2);
            e.cyc  = cyc + 4;
            e.regs = model;
            sb.push_back(e);
        end
        wait_clks(gap);
    endtask

    // Monitor: every status pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {70'd0, frame_valid, frame_err}, 72'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {70'd0, frame_valid, frame_err},
                    e.err ? 72'd1 : 72'd2);
                chk("pulse_cycle", 72'(cyc), 72'(e.cyc));
                chk("regs_at_pulse", dut_regs, e.regs);
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic       seen;
        int         waited;
        model = '0;

        wait_clks(3);
        chk("reset_regs", dut_regs, 72'd0);
        chk("reset_outs", {69'd0, cipo, frame_valid, frame_err}, 72'd0);
        rst_n = 1'b1;
        wait_clks(4);

        model[4] = 8'h55;
        frame(17'h08455, 16, 1, 6, rd, seen);

        model[0] = 8'hFF;
        frame(17'h080FF, 16, 1, 3, rd, seen);
        model[8] = 8'hA3;
        frame(17'h088A3, 16, 1, 6, rd, seen);

        frame(17'h0081A, 12, 2, 6, rd, seen);
        frame({16'h81AB, 1'b1}, 17, 2, 6, rd, seen);
        chk("short_long_reg1", 72'(r1), 72'd0);

        frame(17'h08A12, 16, 2, 6, rd, seen);

        // Reset in the middle of a frame; ncs stays low across the release.
        ncs = 1'b0;
        wait_clks(4);
        send_bits(17'h08177, 9, rd, seen);
        rst_n = 1'b0;
        model = '0;
        wait_clks(2);
        chk("midframe_reset_regs", dut_regs, 72'd0);
        chk("midframe_reset_pulses", {70'd0, frame_valid, frame_err}, 72'd0);
        rst_n = 1'b1;
        wait_clks(6);
        ncs = 1'b1;
        wait_clks(8);
        chk("idle_after_reset_regs", dut_regs, 72'd0);

        model[1] = 8'h77;
        frame(17'h08177, 16, 1, 6, rd, seen);

        model[5] = 8'hC3;
        frame(17'h085C3, 16, 1, 6, rd, seen);
        frame(17'h00500, 16, 0, 6, rd, seen);
`ifdef SPI_READBACK_EN
        chk("readback_data", 72'(rd), 72'hC3);
`else
        chk("cipo_idle", 72'(seen), 72'd0);
`endif
        chk("regs_after_read", dut_regs, model);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            wait_clks(1);
            waited++;
        end
        chk("scoreboard_drained", 72'(sb.size()), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
